align_w_seq: RTL and testbench
==============================

// Module: align_w_seq
// PURPOSE
//  Sequential write-path width converter between a source write port of (1<<S_P_DW_BYTES) bytes and a
//  destination port of (1<<D_P_DW_BYTES) bytes, with byte enables and valid/ready on both sides.
//  Wide-to-narrow requests are split into per-beat transfers, and empty beats are optionally skipped.
//  Narrow-to-wide requests are lane-steered into a single beat. Sits between the LSU/cache write
//  side and a narrower or wider memory/bus port.
// PARAMETERS
//  S_P_DW_BYTES  3   log2 of source data width in bytes
//  D_P_DW_BYTES  2   log2 of destination data width in bytes
//  AW            32  address width
//  SKIP_EMPTY    1   1: wide-to-narrow split omits beats whose byte-enable slice is all zero
// PORTS
//  clk      in   1          clock
//  rst      in   1          synchronous reset, active-high
//  i_valid  in   1          source request valid
//  o_ready  out  1          source request accepted when i_valid & o_ready
//  i_addr   in   AW         source byte address
//  i_dat    in   8<<S_P     source write data
//  i_be     in   1<<S_P     source byte enables
//  o_valid  out  1          destination beat valid
//  i_ready  in   1          destination beat accepted when o_valid & i_ready
//  o_addr   out  AW         beat address; low D_P_DW_BYTES bits always 0
//  o_dat    out  8<<D_P     beat write data
//  o_be     out  1<<D_P     beat byte enables
//  o_last   out  1          final beat of the current source request
// BEHAVIOUR
//  - One clock (clk); rst is synchronous and active-high. During reset: FSM=IDLE; o_valid, o_last,
//    o_addr, o_dat and o_be are 0.
//  - FSM IDLE/BUSY. o_ready = IDLE | (BUSY & o_last & i_ready). This gives zero-bubble back-to-back requests.
//  - Accept: latch addr, dat, be, and beat mask M (one bit per destination beat, set if the slice
//    byte enable is nonzero). Go BUSY. o_valid rises the cycle after acceptance (1-cycle latency).
//  - S==D: one beat. o_dat=dat, o_be=be, o_addr=addr with low D_P bits cleared, o_last=1.
//  - S<D: one beat. o_dat = dat replicated 2^(D_P-S_P) times. o_be = be placed in lane
//    addr[S_P +: D_P-S_P] with all other lanes 0. o_addr = addr with low D_P bits cleared. o_last=1.
//  - S>D: N=2^(S_P-D_P) beats, ascending index k.
//    - Beat k: o_dat=dat[k*8<<D_P +: 8<<D_P], o_be=be slice k, o_addr={addr[AW-1:S_P], k, D_P'b0}.
//    - SKIP_EMPTY=1: only k with M[k]=1 are issued. If M==0, exactly one beat (k=0, o_be=0, o_last=1)
//      is issued so downstream counts stay matched.
//    - SKIP_EMPTY=0: all N beats are issued.
//  - o_last=1 on the highest issued beat. On i_ready during a non-last beat, advance to the next issued
//    k on the next cycle. On i_ready during the last beat: go IDLE, or reload if a new request is
//    accepted in the same cycle.
//  - While o_valid & !i_ready, o_addr, o_dat, o_be and o_last are held stable (AXI-style). o_valid is
//    never withdrawn without a handshake.
//  - Source inputs are sampled only on acceptance; changes while o_ready=0 are ignored.
//  - Reset mid-request discards all pending beats. No beat is issued afterwards for that request.
// TESTING
//  (S_P=3, D_P=2, AW=32 unless noted)
//  1 SKIP_EMPTY=0, addr=0x100, dat=64'h1122334455667788, be=8'hFF, i_ready=1 -> beat0
//    0x100/55667788/F/last0, then beat1 0x104/11223344/F/last1, on consecutive cycles.
//  2 SKIP_EMPTY=1, same request with be=8'hF0 -> single beat 0x104/11223344/be F/last1.
//  3 SKIP_EMPTY=1, be=8'h00 -> single beat 0x100, be 0, last1; o_ready returns high with the handshake.
//  4 i_ready=0 for 3 cycles on beat0 -> beat0 outputs held constant and o_ready=0 throughout; beat1
//    follows the cycle after i_ready rises.
//  5 Two requests presented back-to-back with i_ready=1 -> second accepted in the cycle of the first
//    request's last handshake; o_valid stays high with no idle cycle between requests.
//  6 S_P=2, D_P=3, addr=0x104, dat=32'hAABBCCDD, be=4'hF -> one beat o_addr=0x100,
//    o_dat=64'hAABBCCDDAABBCCDD, o_be=8'hF0, last1.
//  7 rst asserted after beat0 of a 2-beat split -> next cycle o_valid=0, o_ready=1; beat1 is never issued.

Source files
------------

// File: rtl/align_w_seq.sv
// -----------------------------------------------------------------------------
// align_w_seq
//   Sequential write-path width converter. A source write request of
//   (1<<S_P_DW_BYTES) bytes is re-issued on a destination port of
//   (1<<D_P_DW_BYTES) bytes:
//     * wide -> narrow : split into ascending per-beat transfers; beats whose
//                        byte-enable slice is empty are optionally skipped
//     * equal width    : passed through as a single beat
//     * narrow -> wide : data replicated across lanes, byte enables steered
//                        into the lane selected by the address
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_valid / o_ready        source request handshake
//   i_addr, i_dat, i_be      source byte address, write data, byte enables
//   o_valid / i_ready        destination beat handshake
//   o_addr, o_dat, o_be      beat address (destination aligned), data, enables
//   o_last                   final beat of the current source request
// -----------------------------------------------------------------------------
module align_w_seq #(
    parameter int S_P_DW_BYTES = 3,
    parameter int D_P_DW_BYTES = 2,
    parameter int AW           = 32,
    parameter int SKIP_EMPTY   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [AW-1:0]                  i_addr,
    input  logic [(8<<S_P_DW_BYTES)-1:0]   i_dat,
    input  logic [(1<<S_P_DW_BYTES)-1:0]   i_be,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [AW-1:0]                  o_addr,
    output logic [(8<<D_P_DW_BYTES)-1:0]   o_dat,
    output logic [(1<<D_P_DW_BYTES)-1:0]   o_be,
    output logic                           o_last
);

    localparam int S_P   = S_P_DW_BYTES;
    localparam int D_P   = D_P_DW_BYTES;
    localparam int SW    = 8 << S_P;
    localparam int SB    = 1 << S_P;
    localparam int DW    = 8 << D_P;
    localparam int DB    = 1 << D_P;
    localparam bit SPLIT = (S_P > D_P);
    localparam int NB    = SPLIT ? (1 << (S_P - D_P)) : 1;
    localparam int KW    = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [AW-1:0] LOW_D_MASK = AW'((64'd1 << D_P) - 64'd1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Lowest set bit of the beat mask: the first beat to issue.
    function automatic logic [KW-1:0] first_idx(input logic [NB-1:0] m);
        logic [KW-1:0] r;
        r = {KW{1'b0}};
        for (int k = NB - 1; k >= 0; k--) begin
            r = m[k] ? KW'(k) : r;
        end
        return r;
    endfunction

    // Lowest set bit of the beat mask strictly above cur.
    function automatic logic [KW-1:0] next_idx(input logic [NB-1:0] m, input logic [KW-1:0] cur);
        logic [KW-1:0] r;
        logic          found;
        logic          hit;
        r     = cur;
        found = 1'b0;
        for (int k = 0; k < NB; k++) begin
            hit   = !found && m[k] && (KW'(k) > cur);
            r     = hit ? KW'(k) : r;
            found = found | hit;
        end
        return r;
    endfunction

    // True when some beat above cur is still to be issued.
    function automatic logic has_above(input logic [NB-1:0] m, input logic [KW-1:0] cur);
        logic h;
        h = 1'b0;
        for (int k = 0; k < NB; k++) begin
            h = h | (m[k] & (KW'(k) > cur));
        end
        return h;
    endfunction

    logic [0:0]    state_r;
    logic [AW-1:0] addr_r;
    logic [SW-1:0] dat_r;
    logic [SB-1:0] be_r;
    logic [NB-1:0] mask_r;
    logic [KW-1:0] k_r;
    logic [AW-1:0] o_addr_r;
    logic [DW-1:0] o_dat_r;
    logic [DB-1:0] o_be_r;
    logic          o_last_r;

    logic          busy_s;
    logic          accept_s;
    logic          adv_s;
    logic          done_s;
    logic [NB-1:0] in_mask_s;

    logic [AW-1:0] sel_addr_s;
    logic [SW-1:0] sel_dat_s;
    logic [SB-1:0] sel_be_s;
    logic [NB-1:0] sel_mask_s;
    logic [KW-1:0] sel_k_s;

    logic [AW-1:0] beat_addr_s;
    logic [DW-1:0] beat_dat_s;
    logic [DB-1:0] beat_be_s;
    logic          beat_last_s;

    assign busy_s   = (state_r == BUSY);
    assign o_valid  = busy_s;
    // A new request may be taken while the final beat is being handed off.
    assign o_ready  = !busy_s || (o_last_r && i_ready);
    assign accept_s = i_valid && o_ready;
    assign adv_s    = busy_s && i_ready && !o_last_r;
    assign done_s   = busy_s && i_ready && o_last_r;

    assign o_addr = o_addr_r;
    assign o_dat  = o_dat_r;
    assign o_be   = o_be_r;
    assign o_last = o_last_r;

    generate
        if (SPLIT) begin : g_mask_split
            logic [NB-1:0] raw_mask_s;

            // One mask bit per destination beat; an all-empty request still
            // emits beat 0 so downstream beat counts stay matched.
            always_comb begin
                for (int k = 0; k < NB; k++) begin
                    raw_mask_s[k] = |i_be[k*DB +: DB];
                end
                if (SKIP_EMPTY == 0) begin
                    in_mask_s = {NB{1'b1}};
                end else if (raw_mask_s == {NB{1'b0}}) begin
                    in_mask_s = {{(NB-1){1'b0}}, 1'b1};
                end else begin
                    in_mask_s = raw_mask_s;
                end
            end
        end else begin : g_mask_single
            assign in_mask_s = 1'b1;
        end
    endgenerate

    // Pick the request and beat index that feed the next registered beat:
    // a freshly accepted request wins over advancing the current one.
    always_comb begin
        if (accept_s) begin
            sel_addr_s = i_addr;
            sel_dat_s  = i_dat;
            sel_be_s   = i_be;
            sel_mask_s = in_mask_s;
            sel_k_s    = first_idx(in_mask_s);
        end else begin
            sel_addr_s = addr_r;
            sel_dat_s  = dat_r;
            sel_be_s   = be_r;
            sel_mask_s = mask_r;
            sel_k_s    = next_idx(mask_r, k_r);
        end
    end

    generate
        if (SPLIT) begin : g_beat_split
            // Slice k of the wide request; address carries k above the
            // destination offset bits.
            always_comb begin
                beat_addr_s            = sel_addr_s;
                beat_addr_s[S_P-1:0]   = {S_P{1'b0}};
                beat_addr_s[D_P +: KW] = sel_k_s;
                beat_dat_s             = sel_dat_s[sel_k_s*DW +: DW];
                beat_be_s              = sel_be_s[sel_k_s*DB +: DB];
                beat_last_s            = !has_above(sel_mask_s, sel_k_s);
            end
        end else if (S_P == D_P) begin : g_beat_equal
            logic unused_s;

            assign unused_s    = ^{sel_mask_s, sel_k_s};
            assign beat_addr_s = sel_addr_s & ~LOW_D_MASK;
            assign beat_dat_s  = sel_dat_s;
            assign beat_be_s   = sel_be_s;
            assign beat_last_s = 1'b1;
        end else begin : g_beat_widen
            localparam int LW = D_P - S_P;
            localparam int R  = 1 << LW;
            logic [LW-1:0] lane_s;
            logic [DB-1:0] be_ext_s;
            logic          unused_s;

            assign unused_s = ^{sel_mask_s, sel_k_s};
            assign lane_s   = sel_addr_s[S_P +: LW];

            // Replicate data into every lane; enables only in the addressed lane.
            always_comb begin
                be_ext_s    = {{(DB-SB){1'b0}}, sel_be_s};
                beat_addr_s = sel_addr_s & ~LOW_D_MASK;
                beat_dat_s  = {R{sel_dat_s}};
                beat_be_s   = be_ext_s << (lane_s * SB);
                beat_last_s = 1'b1;
            end
        end
    endgenerate

    // FSM, latched request and registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            addr_r   <= {AW{1'b0}};
            dat_r    <= {SW{1'b0}};
            be_r     <= {SB{1'b0}};
            mask_r   <= {NB{1'b0}};
            k_r      <= {KW{1'b0}};
            o_addr_r <= {AW{1'b0}};
            o_dat_r  <= {DW{1'b0}};
            o_be_r   <= {DB{1'b0}};
            o_last_r <= 1'b0;
        end else if (accept_s) begin
            state_r  <= BUSY;
            addr_r   <= i_addr;
            dat_r    <= i_dat;
            be_r     <= i_be;
            mask_r   <= in_mask_s;
            k_r      <= sel_k_s;
            o_addr_r <= beat_addr_s;
            o_dat_r  <= beat_dat_s;
            o_be_r   <= beat_be_s;
            o_last_r <= beat_last_s;
        end else if (adv_s) begin
            k_r      <= sel_k_s;
            o_addr_r <= beat_addr_s;
            o_dat_r  <= beat_dat_s;
            o_be_r   <= beat_be_s;
            o_last_r <= beat_last_s;
        end else if (done_s) begin
            state_r  <= IDLE;
            o_last_r <= 1'b0;
        end else begin
            state_r  <= state_r;
        end
    end

endmodule

// File: tb/tb_align_w_seq.sv
// -----------------------------------------------------------------------------
// tb_align_w_seq
//   Three instances of align_w_seq: 8->4 bytes with empty-beat skipping,
//   8->4 bytes without skipping, 4->8 bytes. Per-instance drivers push the
//   beats a request should produce into a queue at acceptance; a monitor
//   compares every presented beat (and o_ready / o_valid) against the head.
// -----------------------------------------------------------------------------
module tb_align_w_seq;

    localparam int ND = 3;
    localparam int NDIR = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] dat;
        logic [7:0]  be;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] dat;
        logic [7:0]  be;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_en;
    int   nchecks;
    int   nerr;

    logic        valid_in [ND];
    logic        ready_in [ND];
    logic [31:0] addr_in  [ND];
    logic [63:0] dat_in   [ND];
    logic [7:0]  be_in    [ND];

    wire [ND-1:0] valid_out;
    wire [ND-1:0] ready_out;
    wire [ND-1:0] last_out;
    wire [31:0]   addr_a, addr_b, addr_c;
    wire [31:0]   dat_a, dat_b;
    wire [63:0]   dat_c;
    wire [3:0]    be_a, be_b;
    wire [7:0]    be_c;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    always #5 clk = ~clk;

    align_w_seq #(.S_P_DW_BYTES(3), .D_P_DW_BYTES(2), .AW(32), .SKIP_EMPTY(1)) dut_skip (
        .clk(clk), .rst(rst),
        .i_valid(valid_in[0]), .o_ready(ready_out[0]),
        .i_addr(addr_in[0]), .i_dat(dat_in[0]), .i_be(be_in[0]),
        .o_valid(valid_out[0]), .i_ready(ready_in[0]),
        .o_addr(addr_a), .o_dat(dat_a), .o_be(be_a), .o_last(last_out[0])
    );

    align_w_seq #(.S_P_DW_BYTES(3), .D_P_DW_BYTES(2), .AW(32), .SKIP_EMPTY(0)) dut_noskip (
        .clk(clk), .rst(rst),
        .i_valid(valid_in[1]), .o_ready(ready_out[1]),
        .i_addr(addr_in[1]), .i_dat(dat_in[1]), .i_be(be_in[1]),
        .o_valid(valid_out[1]), .i_ready(ready_in[1]),
        .o_addr(addr_b), .o_dat(dat_b), .o_be(be_b), .o_last(last_out[1])
    );

    align_w_seq #(.S_P_DW_BYTES(2), .D_P_DW_BYTES(3), .AW(32), .SKIP_EMPTY(1)) dut_widen (
        .clk(clk), .rst(rst),
        .i_valid(valid_in[2]), .o_ready(ready_out[2]),
        .i_addr(addr_in[2]), .i_dat(dat_in[2][31:0]), .i_be(be_in[2][3:0]),
        .o_valid(valid_out[2]), .i_ready(ready_in[2]),
        .o_addr(addr_c), .o_dat(dat_c), .o_be(be_c), .o_last(last_out[2])
    );

    function automatic int sp_of(int d);
        return (d == 2) ? 2 : 3;
    endfunction

    function automatic int dp_of(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int skip_of(int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qfront(int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(int d);
        case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(int d, beat_t b);
        case (d)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic void qclear(int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic beat_t cur_out(int d);
        beat_t b;
        case (d)
            0:       b = '{addr: addr_a, dat: {32'h0, dat_a}, be: {4'h0, be_a}, last: last_out[0]};
            1:       b = '{addr: addr_b, dat: {32'h0, dat_b}, be: {4'h0, be_b}, last: last_out[1]};
            default: b = '{addr: addr_c, dat: dat_c, be: be_c, last: last_out[2]};
        endcase
        return b;
    endfunction

    function automatic void chk(int d, string name, logic [63:0] act, logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endfunction

    // Reference model: the beats a request must produce, from the byte-level rules.
    function automatic void expect_req(int d, req_t r);
        int    sb, db, n, lane;
        int    ks[$];
        logic  nz;
        beat_t b;
        sb = 1 << sp_of(d);
        db = 1 << dp_of(d);
        if (sb <= db) begin
            b      = '0;
            b.addr = r.addr & ~32'(db - 1);
            lane   = int'((r.addr / sb) % (db / sb));
            for (int j = 0; j < db; j++) begin
                b.dat[8*j +: 8] = r.dat[8*(j % sb) +: 8];
                b.be[j]         = ((j / sb) == lane) ? r.be[j % sb] : 1'b0;
            end
            b.last = 1'b1;
            qpush(d, b);
        end else begin
            n = sb / db;
            for (int k = 0; k < n; k++) begin
                nz = 1'b0;
                for (int j = 0; j < db; j++) nz = nz | r.be[k*db + j];
                if (nz || skip_of(d) == 0) ks.push_back(k);
            end
            if (ks.size() == 0) ks.push_back(0);
            for (int i = 0; i < ks.size(); i++) begin
                b      = '0;
                b.addr = (r.addr & ~32'(sb - 1)) + 32'(ks[i] * db);
                for (int j = 0; j < db; j++) begin
                    b.dat[8*j +: 8] = r.dat[8*(ks[i]*db + j) +: 8];
                    b.be[j]         = r.be[ks[i]*db + j];
                end
                b.last = (i == ks.size() - 1);
                qpush(d, b);
            end
        end
    endfunction

    function automatic req_t dir_req(int d, int i);
        req_t r;
        case (d * 4 + i)
            0:  r = '{32'h100, 64'h1122334455667788, 8'hF0};
            1:  r = '{32'h100, 64'h1122334455667788, 8'h00};
            2:  r = '{32'h100, 64'h1122334455667788, 8'hFF};
            3:  r = '{32'h10C, 64'h0102030405060708, 8'h0F};
            4:  r = '{32'h100, 64'h1122334455667788, 8'hFF};
            5:  r = '{32'h200, 64'hCAFEF00D12345678, 8'h00};
            6:  r = '{32'h300, 64'h8877665544332211, 8'h0F};
            7:  r = '{32'h304, 64'h0F0E0D0C0B0A0908, 8'hF0};
            8:  r = '{32'h104, 64'h00000000AABBCCDD, 8'h0F};
            9:  r = '{32'h100, 64'h0000000012345678, 8'h03};
            10: r = '{32'h10B, 64'h0000000055667788, 8'h0C};
            default: r = '{32'h000, 64'h0000000000000000, 8'h00};
        endcase
        return r;
    endfunction

    function automatic req_t rand_req(int d);
        req_t        r;
        logic [7:0]  rb;
        r.addr = $urandom;
        r.dat  = {$urandom, $urandom};
        rb     = 8'($urandom);
        case ($urandom_range(0, 3))
            0:       r.be = 8'h00;
            1:       r.be = rb & 8'h0F;
            2:       r.be = rb & 8'hF0;
            default: r.be = rb;
        endcase
        if (sp_of(d) == 2) begin
            r.dat[63:32] = 32'h0;
            r.be[7:4]    = 4'h0;
        end
        return r;
    endfunction

    // Monitor: compare what each instance presents with the scoreboard head.
    task automatic mon(int d);
        int    sz;
        logic  exp_rdy;
        beat_t act;
        beat_t exp;
        sz      = qsize(d);
        exp_rdy = (sz == 0) || (sz == 1 && ready_in[d]);
        chk(d, "o_ready", 64'(ready_out[d]), 64'(exp_rdy));
        chk(d, "o_valid", 64'(valid_out[d]), 64'(sz != 0));
        if (valid_out[d] && sz != 0) begin
            exp = qfront(d);
            act = cur_out(d);
            chk(d, "o_addr", 64'(act.addr), 64'(exp.addr));
            chk(d, "o_dat", act.dat, exp.dat);
            chk(d, "o_be", 64'(act.be), 64'(exp.be));
            chk(d, "o_last", 64'(act.last), 64'(exp.last));
            if (ready_in[d]) qpop(d);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) mon(d);
        end
    end

    // Driver: directed requests with i_ready=1 back-to-back, then random traffic.
    task automatic drive(int d, int nrand);
        int   idx;
        int   wait_cyc;
        logic have;
        req_t r;
        idx      = 0;
        wait_cyc = 0;
        have     = 1'b0;
        r        = '0;
        while (idx < NDIR + nrand) begin
            @(posedge clk);
            #1;
            ready_in[d] = (idx < NDIR) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!have) begin
                if (idx >= NDIR && $urandom_range(0, 4) == 0) begin
                    valid_in[d] = 1'b0;
                    addr_in[d]  = $urandom;
                    dat_in[d]   = {$urandom, $urandom};
                    be_in[d]    = 8'($urandom);
                end else begin
                    r           = (idx < NDIR) ? dir_req(d, idx) : rand_req(d);
                    valid_in[d] = 1'b1;
                    addr_in[d]  = r.addr;
                    dat_in[d]   = r.dat;
                    be_in[d]    = r.be;
                    have        = 1'b1;
                    wait_cyc    = 0;
                end
            end
            @(negedge clk);
            #1;
            if (have) begin
                if (ready_out[d]) begin
                    expect_req(d, r);
                    idx++;
                    have = 1'b0;
                end else begin
                    wait_cyc++;
                    if (wait_cyc > 100) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL accept_timeout dut%0d: got no o_ready expected acceptance", d);
                        idx++;
                        have        = 1'b0;
                        valid_in[d] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        valid_in[d] = 1'b0;
        ready_in[d] = 1'b1;
    endtask

    task automatic wait_drain(int budget);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        nchecks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            nerr++;
            $display("FAIL drain: got %0d beats outstanding expected 0", q0.size() + q1.size() + q2.size());
        end
    endtask

    // Reset after beat0 of a two-beat split: beat1 must never appear.
    task automatic reset_mid(int d);
        req_t r;
        r = '{32'h400, 64'hDEADBEEF01234567, 8'hFF};
        @(posedge clk);
        #1;
        valid_in[d] = 1'b1;
        addr_in[d]  = r.addr;
        dat_in[d]   = r.dat;
        be_in[d]    = r.be;
        ready_in[d] = 1'b1;
        @(negedge clk);
        #1;
        expect_req(d, r);
        @(posedge clk);
        #1;
        valid_in[d] = 1'b0;
        @(posedge clk);
        #1;
        ready_in[d] = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qclear(d);
        ready_in[d] = 1'b1;
        @(negedge clk);
        #1;
        chk(d, "rst_mid_valid", 64'(valid_out[d]), 64'd0);
        chk(d, "rst_mid_ready", 64'(ready_out[d]), 64'd1);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nchecks = 0;
        nerr    = 0;
        mon_en  = 1'b0;
        rst     = 1'b1;
        for (int d = 0; d < ND; d++) begin
            valid_in[d] = 1'b0;
            ready_in[d] = 1'b1;
            addr_in[d]  = 32'h0;
            dat_in[d]   = 64'h0;
            be_in[d]    = 8'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            beat_t b;
            b = cur_out(d);
            chk(d, "rst_valid", 64'(valid_out[d]), 64'd0);
            chk(d, "rst_ready", 64'(ready_out[d]), 64'd1);
            chk(d, "rst_last", 64'(b.last), 64'd0);
            chk(d, "rst_addr", 64'(b.addr), 64'd0);
            chk(d, "rst_dat", b.dat, 64'd0);
            chk(d, "rst_be", 64'(b.be), 64'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        fork
            drive(0, 60);
            drive(1, 60);
            drive(2, 60);
        join
        wait_drain(400);
        reset_mid(0);
        reset_mid(1);
        wait_drain(50);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
